program_loader: RTL and testbench

- Serial-to-RAM boot loader upstream of the CPU datapath.
- Accepts a framed byte stream (count header, 16-bit words, XOR checksum).
- Writes each assembled word into the dual-port RAM through port B.
- Holds the CPU in reset until the image is fully written and verified, then releases it so fetch starts from a known image instead of the INIT_FILE contents.

---
 rtl/program_loader.sv | 165 ++++++++++++++++
 tb/tb_program_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: assembles a framed byte stream (count, 16-bit words, XOR checksum)
// into RAM port-B writes and keeps the CPU in reset until the image is verified.
module program_loader #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              skip,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_data,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_t            r_state, w_state_next;
  logic [15:0]       r_count, w_count_next;
  logic [15:0]       r_index, w_index_next;
  logic [7:0]        r_xsum, w_xsum_next;
  logic [7:0]        r_word_hi, w_word_hi_next;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_next;
  logic [15:0]       r_ram_data, w_ram_data_next;
  logic              r_ram_we, w_ram_we_next;
  logic              r_cpu_hold, w_cpu_hold_next;
  logic              r_done, w_done_next;
  logic              r_err, w_err_next;

  logic              w_xfer;
  logic [15:0]       w_count_full;
  logic [15:0]       w_index_inc;

  assign byte_ready   = (r_state != S_WRITE) && (r_state != S_DONE) && (r_state != S_ERR);
  assign w_xfer       = byte_valid && byte_ready;
  assign w_count_full = {r_count[15:8], byte_data};
  assign w_index_inc  = r_index + 16'd1;

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_index_next    = r_index;
    w_xsum_next     = r_xsum;
    w_word_hi_next  = r_word_hi;
    w_ram_addr_next = r_ram_addr;
    w_ram_data_next = r_ram_data;
    w_ram_we_next   = 1'b0;
    w_cpu_hold_next = r_cpu_hold;
    w_done_next     = r_done;
    w_err_next      = r_err;

    case (r_state)
      S_CNT_HI: begin
        // A byte arriving together with skip takes priority over skip.
        if (w_xfer) begin
          w_count_next = {byte_data, 8'h00};
          w_state_next = S_CNT_LO;
        end else if (skip) begin
          w_cpu_hold_next = 1'b0;
          w_done_next     = 1'b1;
          w_state_next    = S_DONE;
        end
      end
      S_CNT_LO: begin
        if (w_xfer) begin
          w_count_next = w_count_full;
          if ((w_count_full == 16'd0) || ({1'b0, w_count_full} > DEPTH)) begin
            w_err_next   = 1'b1;
            w_state_next = S_ERR;
          end else begin
            w_state_next = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (w_xfer) begin
          w_word_hi_next = byte_data;
          w_xsum_next    = r_xsum ^ byte_data;
          w_state_next   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        // Write strobe, address and data are registered on entry to WRITE.
        if (w_xfer) begin
          w_xsum_next     = r_xsum ^ byte_data;
          w_ram_addr_next = BASE_ADDR + r_index[ADDR_W-1:0];
          w_ram_data_next = {r_word_hi, byte_data};
          w_ram_we_next   = 1'b1;
          w_state_next    = S_WRITE;
        end
      end
      S_WRITE: begin
        w_index_next = w_index_inc;
        w_state_next = (w_index_inc == r_count) ? S_CHK : S_DATA_HI;
      end
      S_CHK: begin
        if (w_xfer) begin
          if (byte_data == r_xsum) begin
            w_cpu_hold_next = 1'b0;
            w_done_next     = 1'b1;
            w_state_next    = S_DONE;
          end else begin
            w_err_next   = 1'b1;
            w_state_next = S_ERR;
          end
        end
      end
      S_DONE: ;
      S_ERR:  ;
      default: w_state_next = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CNT_HI;
      r_count    <= 16'd0;
      r_index    <= 16'd0;
      r_xsum     <= 8'd0;
      r_word_hi  <= 8'd0;
      r_ram_addr <= BASE_ADDR;
      r_ram_data <= 16'd0;
      r_ram_we   <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_index    <= w_index_next;
      r_xsum     <= w_xsum_next;
      r_word_hi  <= w_word_hi_next;
      r_ram_addr <= w_ram_addr_next;
      r_ram_data <= w_ram_data_next;
      r_ram_we   <= w_ram_we_next;
      r_cpu_hold <= w_cpu_hold_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
    end
  end

  assign ram_addr = r_ram_addr;
  assign ram_data = r_ram_data;
  assign ram_we   = r_ram_we;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (base 0x000 and 0x3FF) share one byte
// stream; a frame-level model predicts writes and the final done/err outcome.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst, skip, byte_valid;
  logic [7:0] byte_data;

  logic        br0, we0, hold0, done0, err0;
  logic [9:0]  addr0;
  logic [15:0] data0;
  logic        br1, we1, hold1, done1, err1;
  logic [9:0]  addr1;
  logic [15:0] data1;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(10), .BASE_ADDR(10'h000)) u_dut (
    .clk(clk), .rst(rst), .skip(skip), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(br0), .ram_addr(addr0), .ram_data(data0), .ram_we(we0),
    .cpu_hold(hold0), .done(done0), .err(err0)
  );

  program_loader #(.ADDR_W(10), .BASE_ADDR(10'h3FF)) u_dut_wrap (
    .clk(clk), .rst(rst), .skip(skip), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(br1), .ram_addr(addr1), .ram_data(data1), .ram_we(we1),
    .cpu_hold(hold1), .done(done1), .err(err1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  logic [7:0]  stim[$];
  logic [15:0] exp_words[$];
  bit          exp_done, exp_err;
  int          exp_nbytes;

  logic [25:0] wr0[$], wr1[$];
  logic [15:0] mem0[0:1023];

  // Observe RAM writes away from the active edge; mem0 plays the role of the RAM.
  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      wr0.push_back({addr0, data0});
      mem0[addr0] = data0;
    end
    if (we1 === 1'b1) wr1.push_back({addr1, data1});
    if (we0 === 1'b1 && br0 === 1'b1) overlap++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // Frame-level reference: count header, then words, then XOR of data bytes.
  task automatic model_stream();
    int cnt;
    logic [7:0] x;
    exp_words.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    x = 8'h00;
    cnt = int'({stim[0], stim[1]});
    if (cnt == 0 || cnt > 1024) begin
      exp_err    = 1'b1;
      exp_nbytes = 2;
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      exp_words.push_back({stim[2+2*i], stim[3+2*i]});
      x = x ^ stim[2+2*i] ^ stim[3+2*i];
    end
    exp_nbytes = 3 + 2 * cnt;
    exp_done   = (stim[2+2*cnt] == x);
    exp_err    = !exp_done;
  endtask

  task automatic build_random(input int cnt, input bit corrupt);
    logic [15:0] c;
    logic [7:0]  x, b;
    c = 16'(cnt);
    x = 8'h00;
    stim.delete();
    stim.push_back(c[15:8]);
    stim.push_back(c[7:0]);
    for (int i = 0; i < 2 * cnt; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      stim.push_back(b);
    end
    if (corrupt) x = x ^ 8'(1 << $urandom_range(7));
    stim.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    skip = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr0.delete();
    wr1.delete();
  endtask

  // Sends stim[start .. exp_nbytes-1]; starts and ends just after a falling edge.
  task automatic drive(input int gap_pct, input int start);
    int w;
    for (int k = start; k < exp_nbytes; k++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = stim[k];
      w = 0;
      while (br0 !== 1'b1 && w < 16) begin
        @(negedge clk);
        w++;
      end
      if (br0 !== 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL drive_timeout: byte %0d byte_ready=%b, required 1 within 16 cycles", k, br0);
        byte_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (hold0 !== 1'b1)   begin n_fail++; $display("FAIL reset_hold: got %b want 1", hold0); end
    n_checks++; if (done0 !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
    n_checks++; if (err0 !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b want 0", err0); end
    n_checks++; if (we0 !== 1'b0)     begin n_fail++; $display("FAIL reset_we: got %b want 0", we0); end
    n_checks++; if (br0 !== 1'b1)     begin n_fail++; $display("FAIL reset_ready: got %b want 1", br0); end
    n_checks++; if (addr0 !== 10'h000) begin n_fail++; $display("FAIL reset_addr: got %h want 000", addr0); end
    n_checks++; if (addr1 !== 10'h3FF) begin n_fail++; $display("FAIL reset_addr_wrap: got %h want 3ff", addr1); end
    n_checks++; if (data0 !== 16'h0)  begin n_fail++; $display("FAIL reset_data: got %h want 0000", data0); end
    $display("test_reset: done");
  endtask

  task automatic test_normal();
    do_reset();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    model_stream();
    drive(0, 0);
    n_checks++; if (wr0.size() != 2) begin n_fail++; $display("FAIL normal_nwrites: got %0d want 2", wr0.size()); end
    n_checks++; if ((wr0.size() > 0 ? wr0[0] : 26'hx) !== {10'h000, 16'h1234})
      begin n_fail++; $display("FAIL normal_wr0: got %h want %h", (wr0.size() > 0 ? wr0[0] : 26'hx), {10'h000, 16'h1234}); end
    n_checks++; if ((wr0.size() > 1 ? wr0[1] : 26'hx) !== {10'h001, 16'hABCD})
      begin n_fail++; $display("FAIL normal_wr1: got %h want %h", (wr0.size() > 1 ? wr0[1] : 26'hx), {10'h001, 16'hABCD}); end
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL normal_done: got %b want 1", done0); end
    n_checks++; if (hold0 !== 1'b0) begin n_fail++; $display("FAIL normal_hold: got %b want 0", hold0); end
    n_checks++; if (err0 !== 1'b0)  begin n_fail++; $display("FAIL normal_err: got %b want 0", err0); end
    n_checks++; if (br0 !== 1'b0)   begin n_fail++; $display("FAIL normal_ready_done: got %b want 0", br0); end
    $display("test_normal: writes=%0d done=%b hold=%b", wr0.size(), done0, hold0);
  endtask

  task automatic test_bad_checksum();
    do_reset();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    model_stream();
    drive(0, 0);
    n_checks++; if (wr0.size() != 2) begin n_fail++; $display("FAIL badchk_nwrites: got %0d want 2", wr0.size()); end
    n_checks++; if (err0 !== 1'b1)  begin n_fail++; $display("FAIL badchk_err: got %b want 1", err0); end
    n_checks++; if (hold0 !== 1'b1) begin n_fail++; $display("FAIL badchk_hold: got %b want 1", hold0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL badchk_done: got %b want 0", done0); end
    n_checks++; if (br0 !== 1'b0)   begin n_fail++; $display("FAIL badchk_ready: got %b want 0", br0); end
    $display("test_bad_checksum: writes=%0d err=%b", wr0.size(), err0);
  endtask

  task automatic test_bad_count();
    for (int t = 0; t < 2; t++) begin
      do_reset();
      if (t == 0) stim = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h26};
      else        stim = '{8'h04, 8'h01, 8'h12, 8'h34, 8'h26};
      model_stream();
      drive(0, 0);
      byte_valid = 1'b1;
      byte_data  = 8'h12;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      n_checks++; if (err0 !== 1'b1)   begin n_fail++; $display("FAIL badcnt%0d_err: got %b want 1", t, err0); end
      n_checks++; if (wr0.size() != 0) begin n_fail++; $display("FAIL badcnt%0d_nwrites: got %0d want 0", t, wr0.size()); end
      n_checks++; if (br0 !== 1'b0)    begin n_fail++; $display("FAIL badcnt%0d_ready: got %b want 0", t, br0); end
      n_checks++; if (hold0 !== 1'b1)  begin n_fail++; $display("FAIL badcnt%0d_hold: got %b want 1", t, hold0); end
      $display("test_bad_count[%0d]: header %h%h err=%b writes=%0d", t, stim[0], stim[1], err0, wr0.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    stim = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03};
    model_stream();
    drive(0, 0);
    n_checks++; if (wr1.size() != 2) begin n_fail++; $display("FAIL wrap_nwrites: got %0d want 2", wr1.size()); end
    n_checks++; if ((wr1.size() > 0 ? wr1[0] : 26'hx) !== {10'h3FF, 16'h0001})
      begin n_fail++; $display("FAIL wrap_wr0: got %h want %h", (wr1.size() > 0 ? wr1[0] : 26'hx), {10'h3FF, 16'h0001}); end
    n_checks++; if ((wr1.size() > 1 ? wr1[1] : 26'hx) !== {10'h000, 16'h0002})
      begin n_fail++; $display("FAIL wrap_wr1: got %h want %h", (wr1.size() > 1 ? wr1[1] : 26'hx), {10'h000, 16'h0002}); end
    n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL wrap_done: got %b want 1", done1); end
    $display("test_wrap: writes=%0d done=%b", wr1.size(), done1);
  endtask

  // Random frames; even iterations keep byte_valid high throughout.
  task automatic test_back_to_back();
    int bad;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      build_random($urandom_range(1, 8), ($urandom_range(3) == 0));
      model_stream();
      drive((it % 2 == 0) ? 0 : 40, 0);
      bad = 0;
      for (int i = 0; i < exp_words.size() && i < wr0.size() && i < wr1.size(); i++) begin
        if (wr0[i] !== {10'(i), exp_words[i]}) bad++;
        if (wr1[i] !== {10'(10'h3FF + 10'(i)), exp_words[i]}) bad++;
      end
      n_checks++; if (wr0.size() != exp_words.size() || wr1.size() != exp_words.size())
        begin n_fail++; $display("FAIL b2b%0d_nwrites: got %0d/%0d want %0d", it, wr0.size(), wr1.size(), exp_words.size()); end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b%0d_writes: got %0d wrong entries want 0", it, bad); end
      n_checks++; if (done0 !== exp_done) begin n_fail++; $display("FAIL b2b%0d_done: got %b want %b", it, done0, exp_done); end
      n_checks++; if (err0 !== exp_err)   begin n_fail++; $display("FAIL b2b%0d_err: got %b want %b", it, err0, exp_err); end
      n_checks++; if (hold0 !== !exp_done) begin n_fail++; $display("FAIL b2b%0d_hold: got %b want %b", it, hold0, !exp_done); end
      $display("test_back_to_back[%0d]: words=%0d writes=%0d done=%b err=%b", it, exp_words.size(), wr0.size(), done0, err0);
    end
    n_checks++; if (overlap != 0) begin n_fail++; $display("FAIL ready_in_write: got %0d cycles want 0", overlap); end
  endtask

  task automatic test_full_fill();
    int bad;
    do_reset();
    build_random(1024, 1'b0);
    model_stream();
    drive(0, 0);
    bad = 0;
    for (int i = 0; i < exp_words.size() && i < wr0.size() && i < wr1.size(); i++) begin
      if (wr0[i] !== {10'(i), exp_words[i]}) bad++;
      if (wr1[i] !== {10'(10'h3FF + 10'(i)), exp_words[i]}) bad++;
    end
    n_checks++; if (wr0.size() != 1024 || wr1.size() != 1024)
      begin n_fail++; $display("FAIL full_nwrites: got %0d/%0d want 1024", wr0.size(), wr1.size()); end
    n_checks++; if (bad != 0)      begin n_fail++; $display("FAIL full_writes: got %0d wrong entries want 0", bad); end
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b want 1", done0); end
    $display("test_full_fill: writes=%0d done=%b", wr0.size(), done0);
  endtask

  task automatic test_reset_mid_load_skip();
    logic [15:0] w0;
    do_reset();
    build_random(3, 1'b0);
    model_stream();
    w0 = exp_words[0];
    exp_nbytes = 4;
    drive(0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (hold0 !== 1'b1)  begin n_fail++; $display("FAIL midrst_hold: got %b want 1", hold0); end
    n_checks++; if (br0 !== 1'b1)    begin n_fail++; $display("FAIL midrst_ready: got %b want 1", br0); end
    n_checks++; if (done0 !== 1'b0)  begin n_fail++; $display("FAIL midrst_done: got %b want 0", done0); end
    n_checks++; if (wr0.size() != 1) begin n_fail++; $display("FAIL midrst_nwrites: got %0d want 1", wr0.size()); end
    n_checks++; if (mem0[0] !== w0)  begin n_fail++; $display("FAIL midrst_mem0: got %h want %h", mem0[0], w0); end
    skip = 1'b1;
    @(negedge clk);
    skip = 1'b0;
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL skip_done: got %b want 1", done0); end
    n_checks++; if (hold0 !== 1'b0) begin n_fail++; $display("FAIL skip_hold: got %b want 0", hold0); end
    n_checks++; if (br0 !== 1'b0)   begin n_fail++; $display("FAIL skip_ready: got %b want 0", br0); end
    repeat (3) @(negedge clk);
    n_checks++; if (wr0.size() != 1 || we0 !== 1'b0)
      begin n_fail++; $display("FAIL skip_nwrites: got %0d we=%b want 1 we=0", wr0.size(), we0); end
    $display("test_reset_mid_load_skip: mem0[0]=%h done=%b hold=%b", mem0[0], done0, hold0);

    // skip coinciding with a byte: the byte is taken and loading proceeds.
    do_reset();
    stim = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h66};
    model_stream();
    skip = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h00;
    @(negedge clk);
    skip = 1'b0;
    byte_valid = 1'b0;
    n_checks++; if (done0 !== 1'b0 || hold0 !== 1'b1)
      begin n_fail++; $display("FAIL skip_vs_xfer: got done=%b hold=%b want done=0 hold=1", done0, hold0); end
    drive(0, 1);
    n_checks++; if (done0 !== 1'b1 || (wr0.size() > 0 ? wr0[0] : 26'hx) !== {10'h000, 16'hABCD})
      begin n_fail++; $display("FAIL skip_vs_xfer_load: got done=%b wr=%h want done=1 wr=%h", done0, (wr0.size() > 0 ? wr0[0] : 26'hx), {10'h000, 16'hABCD}); end
    $display("test_skip_vs_transfer: writes=%0d done=%b", wr0.size(), done0);
  endtask

  initial begin
    rst = 1'b1;
    skip = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    test_reset();
    test_normal();
    test_bad_checksum();
    test_bad_count();
    test_wrap();
    test_back_to_back();
    test_full_fill();
    test_reset_mid_load_skip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
